// File: rtl/multi_chan_data_sync_if.sv
// Merged output stream of multi_chan_data_sync.
//   out_data   word taken from the granted channel
//   out_chan   index of the channel that produced out_data
//   out_valid  out_data/out_chan hold a word
//   out_ready  consumer accepts the word on this edge
// master: the synchronizer (drives data/chan/valid); slave: the consumer (drives ready).
interface multi_chan_data_sync_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_CHAN  = 4
);
  localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  logic [BUS_WIDTH-1:0] out_data;
  logic [CHAN_W-1:0]    out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/multi_chan_data_sync.sv
// Multi-channel enable-qualified bus synchronizer into the clk domain.
// Each channel passes its enable through a NUM_STAGE flop chain, detects an event
// (rising edge, or any edge when TOGGLE_MODE != 0), pulses enable_pulse for one cycle
// and captures its bus word. Captured words merge into one valid/ready stream through
// a round-robin arbiter; a second event on a still-pending channel sets its sticky
// overrun bit and overwrites the word (latest wins).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   unsync_bus     NUM_CHAN words, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable     per-channel asynchronous qualifier
//   sync_bus       per-channel last captured word
//   enable_pulse   one-cycle pulse per captured event
//   overrun        sticky per-channel overrun flags
//   clr_overrun    clears all overrun flags (a same-edge new overrun wins)
//   out_stream     merged output stream (master side)
module multi_chan_data_sync #(
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHAN*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CHAN-1:0]           bus_enable,
  output logic [NUM_CHAN*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CHAN-1:0]           enable_pulse,
  output logic [NUM_CHAN-1:0]           overrun,
  input  logic                          clr_overrun,
  multi_chan_data_sync_if.master        out_stream
);

  localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  // Edges 1..NUM_STAGE+1 after release are masked: the last of them is where an
  // enable held through reset first reaches the chain end while prev is still 0.
  localparam int unsigned STARTUP = NUM_STAGE + 1;
  localparam int unsigned CNT_W   = $clog2(STARTUP + 1);

  logic [NUM_CHAN-1:0]  sync_q [NUM_STAGE];
  logic [NUM_CHAN-1:0]  prev_q;
  logic [CNT_W-1:0]     startup_q, startup_d;
  logic                 startup_busy;

  logic [BUS_WIDTH-1:0] word_q [NUM_CHAN];
  logic [BUS_WIDTH-1:0] word_d [NUM_CHAN];
  logic [NUM_CHAN-1:0]  pulse_q;
  logic [NUM_CHAN-1:0]  pending_q, pending_d;
  logic [NUM_CHAN-1:0]  overrun_q, overrun_d;

  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic [CHAN_W-1:0]    out_chan_q, out_chan_d;
  logic                 out_valid_q, out_valid_d;
  logic [CHAN_W-1:0]    ptr_q, ptr_d;

  logic [NUM_CHAN-1:0]  edge_raw;
  logic [NUM_CHAN-1:0]  evt;
  logic [NUM_CHAN-1:0]  grant;
  logic [CHAN_W-1:0]    grant_idx;
  logic                 grant_found;
  logic                 can_issue;

  // Event detection on the synchronized enable.
  if (TOGGLE_MODE != 0) begin : g_toggle
    assign edge_raw = sync_q[NUM_STAGE-1] ^ prev_q;
  end else begin : g_level
    assign edge_raw = sync_q[NUM_STAGE-1] & ~prev_q;
  end

  assign startup_busy = (startup_q != '0);
  assign startup_d    = startup_busy ? startup_q - 1'b1 : startup_q;
  assign evt          = startup_busy ? '0 : edge_raw;

  // Round-robin search starting at ptr+1; only already-pending words are eligible,
  // so a word captured on this edge is offered from the next edge on.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 1; i <= NUM_CHAN; i++) begin
      if (!grant_found && pending_q[CHAN_W'((32'(ptr_q) + i) % NUM_CHAN)]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_W'((32'(ptr_q) + i) % NUM_CHAN);
      end
    end
    can_issue = ~out_valid_q | out_stream.out_ready;
    grant     = (can_issue && grant_found) ? (NUM_CHAN'(1) << grant_idx) : '0;
  end

  always_comb begin
    // A grant and a new event on the same channel: the old word leaves, the new one
    // stays pending, and it is not an overrun.
    pending_d = (pending_q & ~grant) | evt;
    overrun_d = (overrun_q & ~{NUM_CHAN{clr_overrun}}) | (evt & pending_q & ~grant);
    for (int c = 0; c < int'(NUM_CHAN); c++) begin
      word_d[c] = evt[c] ? unsync_bus[c*BUS_WIDTH +: BUS_WIDTH] : word_q[c];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (|grant) begin
      out_valid_d = 1'b1;
      out_data_d  = word_q[grant_idx];
      out_chan_d  = grant_idx;
      ptr_d       = grant_idx;
    end else if (out_stream.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_STAGE); i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      startup_q <= CNT_W'(STARTUP);
      pulse_q   <= '0;
      for (int c = 0; c < int'(NUM_CHAN); c++) begin
        word_q[c] <= '0;
      end
      pending_q   <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= CHAN_W'(NUM_CHAN - 1);
    end else begin
      sync_q[0] <= bus_enable;
      for (int i = 1; i < int'(NUM_STAGE); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      // prev keeps tracking during the startup window so held levels never fire.
      prev_q    <= sync_q[NUM_STAGE-1];
      startup_q <= startup_d;
      pulse_q   <= evt;
      for (int c = 0; c < int'(NUM_CHAN); c++) begin
        word_q[c] <= word_d[c];
      end
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_flat
    assign sync_bus[c*BUS_WIDTH +: BUS_WIDTH] = word_q[c];
  end

  assign enable_pulse         = pulse_q;
  assign overrun              = overrun_q;
  assign out_stream.out_data  = out_data_q;
  assign out_stream.out_chan  = out_chan_q;
  assign out_stream.out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_chan_data_sync.sv
// Bench for multi_chan_data_sync: dut0 in level mode, dut1 in toggle mode, sharing
// clk/rst. Expected stream words are queued as stimulus is driven and popped when a
// word is accepted (valid & ready) on the merged output.
module tb_multi_chan_data_sync;

  localparam int unsigned NS = 2;
  localparam int unsigned BW = 8;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC*BW-1:0] bus0 = '0, bus1 = '0;
  logic [NC-1:0]    en0 = '0, en1 = '0;
  logic [NC*BW-1:0] sync0, sync1;
  logic [NC-1:0]    pulse0, pulse1, ovr0, ovr1;
  logic             clr0 = 1'b0, clr1 = 1'b0;

  multi_chan_data_sync_if #(.BUS_WIDTH(BW), .NUM_CHAN(NC)) s0 ();
  multi_chan_data_sync_if #(.BUS_WIDTH(BW), .NUM_CHAN(NC)) s1 ();

  multi_chan_data_sync #(
    .NUM_STAGE(NS), .BUS_WIDTH(BW), .NUM_CHAN(NC), .TOGGLE_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .unsync_bus(bus0), .bus_enable(en0), .sync_bus(sync0),
    .enable_pulse(pulse0), .overrun(ovr0), .clr_overrun(clr0), .out_stream(s0)
  );

  multi_chan_data_sync #(
    .NUM_STAGE(NS), .BUS_WIDTH(BW), .NUM_CHAN(NC), .TOGGLE_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .unsync_bus(bus1), .bus_enable(en1), .sync_bus(sync1),
    .enable_pulse(pulse1), .overrun(ovr1), .clr_overrun(clr1), .out_stream(s1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: {chan[1:0], data[7:0]}
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] e0, e1;

  always @(negedge clk) begin
    if (!rst && s0.out_valid && s0.out_ready) begin
      if (q0.size() == 0) begin
        check_val("dut0_unexpected_word", 32'(q0.size()), 32'd1);
      end else begin
        e0 = q0.pop_front();
        check_val("dut0_out_chan", 32'(s0.out_chan), 32'(e0[9:8]));
        check_val("dut0_out_data", 32'(s0.out_data), 32'(e0[7:0]));
      end
    end
    if (!rst && s1.out_valid && s1.out_ready) begin
      if (q1.size() == 0) begin
        check_val("dut1_unexpected_word", 32'(q1.size()), 32'd1);
      end else begin
        e1 = q1.pop_front();
        check_val("dut1_out_chan", 32'(s1.out_chan), 32'(e1[9:8]));
        check_val("dut1_out_data", 32'(s1.out_data), 32'(e1[7:0]));
      end
    end
  end

  // Pulse counters (a pulse longer than one cycle counts more than once).
  int pc0 [NC];
  int pc1_3 = 0;
  initial for (int c = 0; c < int'(NC); c++) pc0[c] = 0;
  always @(negedge clk) begin
    for (int c = 0; c < int'(NC); c++) if (pulse0[c]) pc0[c]++;
    if (pulse1[3]) pc1_3++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_word0(input int c, input logic [7:0] w);
    bus0[c*BW +: BW] = w;
  endtask

  int base;

  initial begin
    s0.out_ready = 1'b1;
    s1.out_ready = 1'b1;
    cyc(3);
    @(negedge clk);
    check_val("rst_out_valid", 32'(s0.out_valid), 0);
    check_val("rst_out_data", 32'(s0.out_data), 0);
    check_val("rst_out_chan", 32'(s0.out_chan), 0);
    check_val("rst_sync_bus", sync0, 0);
    check_val("rst_overrun", 32'(ovr0), 0);
    check_val("rst_pulse", 32'(pulse0), 0);
    cyc(1);
    rst = 1'b0;
    cyc(5);

    // Single event on ch0: pulse exactly 2 edges after first sample.
    set_word0(0, 8'hA5);
    q0.push_back({2'd0, 8'hA5});
    en0[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("ch0_pulse_n%0d", i), 32'(pulse0[0]), 32'(i == 3));
      if (i == 3) begin
        check_val("ch0_sync_bus", 32'(sync0[7:0]), 32'hA5);
        check_val("ch0_valid_not_yet", 32'(s0.out_valid), 0);
      end
      if (i == 4) check_val("ch0_valid", 32'(s0.out_valid), 1);
    end

    // Enable held high, bus changed: no new event.
    base = pc0[0];
    cyc(1);
    set_word0(0, 8'h5A);
    cyc(6);
    @(negedge clk);
    check_val("held_no_pulse", 32'(pc0[0] - base), 0);
    check_val("held_sync_bus", 32'(sync0[7:0]), 32'hA5);
    check_val("held_valid_drop", 32'(s0.out_valid), 0);
    cyc(1);
    en0[0] = 1'b0;
    cyc(4);

    // Simultaneous ch1..ch3, then ch0+ch3.
    set_word0(1, 8'h21);
    set_word0(2, 8'h32);
    set_word0(3, 8'h43);
    q0.push_back({2'd1, 8'h21});
    q0.push_back({2'd2, 8'h32});
    q0.push_back({2'd3, 8'h43});
    en0[3:1] = 3'b111;
    cyc(4);
    @(negedge clk);
    check_val("rr_first_chan", 32'(s0.out_chan), 1);
    cyc(1);
    @(negedge clk);
    check_val("rr_second_chan", 32'(s0.out_chan), 2);
    cyc(4);
    en0 = '0;
    cyc(4);
    set_word0(0, 8'h0F);
    set_word0(3, 8'hF3);
    q0.push_back({2'd0, 8'h0F});
    q0.push_back({2'd3, 8'hF3});
    en0[0] = 1'b1;
    en0[3] = 1'b1;
    cyc(8);
    en0 = '0;
    cyc(4);
    check_val("rr_queue_drained", 32'(q0.size()), 0);

    // Backpressure and overrun on ch2.
    s0.out_ready = 1'b0;
    set_word0(2, 8'h11);
    q0.push_back({2'd2, 8'h11});
    en0[2] = 1'b1;
    cyc(4);
    en0[2] = 1'b0;
    cyc(4);
    set_word0(2, 8'h22);
    en0[2] = 1'b1;
    cyc(4);
    @(negedge clk);
    check_val("ovr_after_second", 32'(ovr0), 0);
    cyc(1);
    en0[2] = 1'b0;
    cyc(4);
    set_word0(2, 8'h33);
    q0.push_back({2'd2, 8'h33});
    en0[2] = 1'b1;
    cyc(4);
    @(negedge clk);
    check_val("ovr_after_third", 32'(ovr0), 32'h4);
    check_val("held_out_data", 32'(s0.out_data), 32'h11);
    check_val("held_out_valid", 32'(s0.out_valid), 1);
    check_val("ovr_sync_bus", 32'(sync0[2*BW +: BW]), 32'h33);
    cyc(1);
    en0[2] = 1'b0;
    s0.out_ready = 1'b1;
    cyc(4);
    check_val("ovr_queue_drained", 32'(q0.size()), 0);
    check_val("ovr_sticky", 32'(ovr0), 32'h4);
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    @(negedge clk);
    check_val("ovr_cleared", 32'(ovr0), 0);

    // Enable high through reset never fires.
    cyc(1);
    en0[1] = 1'b1;
    rst = 1'b1;
    cyc(3);
    base = pc0[1];
    rst = 1'b0;
    cyc(8);
    @(negedge clk);
    check_val("rst_held_no_pulse", 32'(pc0[1] - base), 0);
    check_val("rst_held_no_valid", 32'(s0.out_valid), 0);
    cyc(1);
    en0[1] = 1'b0;
    cyc(4);

    // Reset while a word is presented.
    s0.out_ready = 1'b0;
    set_word0(0, 8'h77);
    en0[0] = 1'b1;
    cyc(5);
    @(negedge clk);
    check_val("pre_rst_valid", 32'(s0.out_valid), 1);
    check_val("pre_rst_data", 32'(s0.out_data), 32'h77);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    check_val("midrst_valid", 32'(s0.out_valid), 0);
    check_val("midrst_data", 32'(s0.out_data), 0);
    check_val("midrst_sync_bus", sync0, 0);
    check_val("midrst_pulse", 32'(pulse0), 0);
    cyc(1);
    en0 = '0;
    s0.out_ready = 1'b1;
    rst = 1'b0;
    cyc(6);

    // Toggle mode on dut1 ch3.
    base = pc1_3;
    bus1[3*BW +: BW] = 8'h3C;
    q1.push_back({2'd3, 8'h3C});
    en1[3] = 1'b1;
    cyc(6);
    bus1[3*BW +: BW] = 8'hC3;
    q1.push_back({2'd3, 8'hC3});
    en1[3] = 1'b0;
    cyc(6);
    @(negedge clk);
    check_val("toggle_pulses", 32'(pc1_3 - base), 2);
    check_val("toggle_sync_bus", 32'(sync1[3*BW +: BW]), 32'hC3);

    cyc(2);
    check_val("dut0_queue_empty", 32'(q0.size()), 0);
    check_val("dut1_queue_empty", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
